sipo_word_aligner: RTL and testbench

//  Sits directly downstream of the 4-bit I_SERDES in the SIPO receive path, in the SERDES core clock domain.

---
 rtl/sipo_word_aligner.sv | 189 ++++++++++++++++++
 tb/tb_sipo_word_aligner.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sipo_word_aligner.sv
// Gearboxes 4-bit SERDES nibbles into 16-bit words and, while training, hunts for
// TRAIN_PATTERN by pulsing the SERDES bitslip and skipping nibbles.
//   state    | meaning
//   S_IDLE   | not training; words pass through unchecked
//   S_HUNT   | compare each word against TRAIN_PATTERN
//   S_VERIFY | matches seen, counting toward LOCK_COUNT
//   S_SLIP   | BITSLIP_ADJ pulse cycle
//   S_WAIT   | SERDES settling after a slip, gearbox parked
//   S_LOCKED | aligned; drops lock after UNLOCK_COUNT bad training words
//   S_ERROR  | attempts exhausted, held until TRAIN_EN falls
module sipo_word_aligner #(
  parameter logic [15:0] TRAIN_PATTERN = 16'hA3C5,
  parameter int          SLIP_WAIT     = 8,
  parameter int          LOCK_COUNT    = 4,
  parameter int          UNLOCK_COUNT  = 3,
  parameter int          MAX_ATTEMPTS  = 16
) (
  input  logic        CLK_IN,
  input  logic        RST_N,
  input  logic [3:0]  Q_IN,
  input  logic        Q_VALID,
  input  logic        TRAIN_EN,
  output logic        BITSLIP_ADJ,
  output logic [15:0] WORD_OUT,
  output logic        WORD_VALID,
  output logic        ALIGNED,
  output logic        ALIGN_ERROR,
  output logic [4:0]  SLIP_COUNT
);

  localparam int MW = $clog2(LOCK_COUNT + 1);
  localparam int UW = $clog2(UNLOCK_COUNT + 1);
  localparam int WW = $clog2(SLIP_WAIT + 1);
  localparam logic [MW-1:0] LOCK_N   = MW'(LOCK_COUNT);
  localparam logic [UW-1:0] UNLOCK_N = UW'(UNLOCK_COUNT);
  localparam logic [WW-1:0] WAIT_LD  = WW'(SLIP_WAIT - 1);
  localparam logic [4:0]    MAX_N    = 5'(MAX_ATTEMPTS);

  typedef enum logic [2:0] {
    S_IDLE, S_HUNT, S_VERIFY, S_SLIP, S_WAIT, S_LOCKED, S_ERROR
  } state_t;

  state_t        state;
  logic [1:0]    nib_cnt;
  logic [11:0]   partial;
  logic          nibble_skip;
  logic [MW-1:0] match_cnt;
  logic [UW-1:0] miss_cnt;
  logic [WW-1:0] wait_cnt;

  logic          gear_run;
  logic          take;
  logic          word_done;
  logic          word_match;
  logic [15:0]   word_next;
  logic [MW-1:0] match_next;
  logic [UW-1:0] miss_next;
  logic [4:0]    slip_next;

  always_comb begin
    gear_run   = (state != S_SLIP) && (state != S_WAIT);
    take       = Q_VALID && gear_run && !nibble_skip;
    word_done  = take && (nib_cnt == 2'd3);
    word_next  = {partial, Q_IN};
    word_match = (word_next == TRAIN_PATTERN);
    match_next = (state == S_HUNT) ? MW'(1) : match_cnt + MW'(1);
    miss_next  = miss_cnt + UW'(1);
    slip_next  = SLIP_COUNT + 5'd1;
  end

  always_ff @(posedge CLK_IN) begin
    if (!RST_N) begin
      state       <= S_IDLE;
      nib_cnt     <= '0;
      partial     <= '0;
      nibble_skip <= 1'b0;
      match_cnt   <= '0;
      miss_cnt    <= '0;
      wait_cnt    <= '0;
      BITSLIP_ADJ <= 1'b0;
      WORD_OUT    <= '0;
      WORD_VALID  <= 1'b0;
      ALIGNED     <= 1'b0;
      ALIGN_ERROR <= 1'b0;
      SLIP_COUNT  <= '0;
    end else begin
      BITSLIP_ADJ <= 1'b0;
      WORD_VALID  <= 1'b0;

      // the first nibble after a nibble-phase slip is swallowed here
      if (Q_VALID && gear_run) begin
        if (nibble_skip) begin
          nibble_skip <= 1'b0;
        end else begin
          partial <= {partial[7:0], Q_IN};
          nib_cnt <= nib_cnt + 2'd1;
          if (word_done) begin
            WORD_OUT   <= word_next;
            WORD_VALID <= 1'b1;
          end
        end
      end

      case (state)
        S_IDLE: begin
          ALIGNED     <= 1'b0;
          ALIGN_ERROR <= 1'b0;
          if (TRAIN_EN) begin
            state      <= S_HUNT;
            SLIP_COUNT <= '0;
            match_cnt  <= '0;
          end
        end
        S_HUNT, S_VERIFY: begin
          if (!TRAIN_EN) begin
            state       <= S_IDLE;
            SLIP_COUNT  <= '0;
            match_cnt   <= '0;
            nibble_skip <= 1'b0;
          end else if (word_done) begin
            if (word_match) begin
              if (match_next >= LOCK_N) begin
                state     <= S_LOCKED;
                ALIGNED   <= 1'b1;
                miss_cnt  <= '0;
                match_cnt <= '0;
              end else begin
                state     <= S_VERIFY;
                match_cnt <= match_next;
              end
            end else if (SLIP_COUNT < MAX_N) begin
              state       <= S_SLIP;
              BITSLIP_ADJ <= 1'b1;
              SLIP_COUNT  <= slip_next;
              match_cnt   <= '0;
              if (slip_next[1:0] == 2'd0) nibble_skip <= 1'b1;
            end else begin
              state       <= S_ERROR;
              ALIGN_ERROR <= 1'b1;
              match_cnt   <= '0;
            end
          end
        end
        S_SLIP, S_WAIT: begin
          if (!TRAIN_EN) begin
            state       <= S_IDLE;
            SLIP_COUNT  <= '0;
            nibble_skip <= 1'b0;
            nib_cnt     <= '0;
            wait_cnt    <= '0;
          end else if (state == S_SLIP) begin
            state    <= S_WAIT;
            wait_cnt <= WAIT_LD;
          end else if (wait_cnt == '0) begin
            state   <= S_HUNT;
            nib_cnt <= '0;
          end else begin
            wait_cnt <= wait_cnt - WW'(1);
          end
        end
        S_LOCKED: begin
          if (!TRAIN_EN) begin
            miss_cnt <= '0;
          end else if (word_done) begin
            if (word_match) begin
              miss_cnt <= '0;
            end else if (miss_next >= UNLOCK_N) begin
              state      <= S_HUNT;
              ALIGNED    <= 1'b0;
              SLIP_COUNT <= '0;
              miss_cnt   <= '0;
            end else begin
              miss_cnt <= miss_next;
            end
          end
        end
        S_ERROR: begin
          if (!TRAIN_EN) begin
            state       <= S_IDLE;
            ALIGN_ERROR <= 1'b0;
            SLIP_COUNT  <= '0;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sipo_word_aligner.sv
// Scoreboarded bench for sipo_word_aligner: random gearbox traffic plus a bit-level
// SERDES model that honours BITSLIP_ADJ, for the training/lock/error paths.
module tb_sipo_word_aligner;

  localparam logic [15:0] PAT          = 16'hA3C5;
  localparam int          SLIP_WAIT    = 8;
  localparam int          LOCK_COUNT   = 4;
  localparam int          MAX_ATTEMPTS = 16;

  logic        CLK_IN = 1'b0;
  logic        RST_N;
  logic [3:0]  Q_IN;
  logic        Q_VALID;
  logic        TRAIN_EN;
  logic        BITSLIP_ADJ;
  logic [15:0] WORD_OUT;
  logic        WORD_VALID;
  logic        ALIGNED;
  logic        ALIGN_ERROR;
  logic [4:0]  SLIP_COUNT;

  sipo_word_aligner #(
    .TRAIN_PATTERN(PAT),
    .SLIP_WAIT    (SLIP_WAIT),
    .LOCK_COUNT   (LOCK_COUNT),
    .UNLOCK_COUNT (3),
    .MAX_ATTEMPTS (MAX_ATTEMPTS)
  ) dut (
    .CLK_IN     (CLK_IN),
    .RST_N      (RST_N),
    .Q_IN       (Q_IN),
    .Q_VALID    (Q_VALID),
    .TRAIN_EN   (TRAIN_EN),
    .BITSLIP_ADJ(BITSLIP_ADJ),
    .WORD_OUT   (WORD_OUT),
    .WORD_VALID (WORD_VALID),
    .ALIGNED    (ALIGNED),
    .ALIGN_ERROR(ALIGN_ERROR),
    .SLIP_COUNT (SLIP_COUNT)
  );

  always #5 CLK_IN = ~CLK_IN;

  int          checks = 0;
  int          errors = 0;
  logic [15:0] exp_q[$];
  logic [3:0]  nq[$];
  bit          sb_en = 1'b0;

  // serial-stream SERDES model state
  int sd_base, sd_j, sd_b, quiet, pulses, cyc_no, last_pulse;
  bit sd_rand, prev_slip;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  always @(negedge CLK_IN) begin
    if (sb_en && WORD_VALID) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_unexpected_word actual=%0h required=none", WORD_OUT);
      end else begin
        check("sb_word", WORD_OUT, exp_q.pop_front());
      end
    end
  end

  task automatic cyc(input logic [3:0] n, input logic v);
    Q_IN    = n;
    Q_VALID = v;
    @(posedge CLK_IN);
    #1;
  endtask

  task automatic gb_send(input logic [3:0] n);
    nq.push_back(n);
    if (nq.size() == 4) begin
      exp_q.push_back({nq[0], nq[1], nq[2], nq[3]});
      nq.delete();
    end
    cyc(n, 1'b1);
  endtask

  task automatic check_zero(input string name);
    check({name, "_bitslip"}, BITSLIP_ADJ, 0);
    check({name, "_word_out"}, WORD_OUT, 0);
    check({name, "_word_valid"}, WORD_VALID, 0);
    check({name, "_aligned"}, ALIGNED, 0);
    check({name, "_align_error"}, ALIGN_ERROR, 0);
    check({name, "_slip_count"}, SLIP_COUNT, 0);
  endtask

  task automatic do_reset();
    sb_en    = 1'b0;
    RST_N    = 1'b0;
    TRAIN_EN = 1'b0;
    cyc(4'h0, 1'b0);
    cyc(4'h0, 1'b0);
    exp_q.delete();
    nq.delete();
    check_zero("reset");
    RST_N = 1'b1;
  endtask

  task automatic sb_drain(input string name);
    @(negedge CLK_IN);
    #1;
    check(name, exp_q.size(), 0);
    sb_en = 1'b0;
  endtask

  function automatic logic [3:0] pat_nib(input int pos);
    logic [15:0] p;
    logic [3:0]  r;
    p = PAT;
    for (int k = 0; k < 4; k++) r[3-k] = p[15 - ((pos + k) % 16)];
    return r;
  endfunction

  task automatic sd_init(input int base, input bit rnd);
    sd_base = base; sd_rand = rnd; sd_j = 0; sd_b = 0; quiet = 0;
    pulses = 0; cyc_no = 0; last_pulse = 0; prev_slip = 1'b0;
  endtask

  // nibble j is taken at stream bit base+4j+b; a bitslip rotates b within the nibble
  task automatic sd_step();
    logic [3:0] n;
    if (quiet > 0) begin
      quiet--;
      cyc(4'($urandom_range(0, 15)), 1'b0);
    end else begin
      n = sd_rand ? 4'($urandom_range(0, 15)) : pat_nib(sd_base + 4 * sd_j + sd_b);
      sd_j++;
      cyc(n, 1'b1);
    end
    cyc_no++;
    if (prev_slip) begin
      check("slip_pulse_width", BITSLIP_ADJ, 0);
    end else if (BITSLIP_ADJ) begin
      pulses++;
      if (pulses > 1) check("slip_spacing", (cyc_no - last_pulse) >= SLIP_WAIT + 1, 1);
      last_pulse = cyc_no;
      sd_b  = (sd_b + 1) % 4;
      quiet = SLIP_WAIT + 1;
    end
    prev_slip = BITSLIP_ADJ;
  endtask

  task automatic run_aligned(input string tag);
    int          p;
    logic [15:0] pv;
    p        = 0;
    pv       = PAT;
    sb_en    = 1'b1;
    TRAIN_EN = 1'b1;
    for (int w = 0; w < 6; w++) begin
      for (int k = 0; k < 4; k++) begin
        gb_send(pv[15-4*k -: 4]);
        if (BITSLIP_ADJ) p++;
      end
      check($sformatf("%s_aligned_w%0d", tag, w), ALIGNED, (w >= LOCK_COUNT - 1));
      if (w == LOCK_COUNT - 1) check({tag, "_lock_word_valid"}, WORD_VALID, 1);
    end
    check({tag, "_no_pulses"}, p, 0);
    check({tag, "_slip_count"}, SLIP_COUNT, 0);
    check({tag, "_word_out"}, WORD_OUT, PAT);
  endtask

  task automatic send_word(input logic [15:0] w);
    for (int k = 0; k < 4; k++) gb_send(w[15-4*k -: 4]);
  endtask

  function automatic logic [15:0] bad_word();
    logic [15:0] w;
    w = 16'($urandom);
    while (w == PAT) w = 16'($urandom);
    return w;
  endfunction

  initial begin
    int wv;
    RST_N = 1'b0; Q_IN = '0; Q_VALID = 1'b0; TRAIN_EN = 1'b0;
    do_reset();

    // random gearbox traffic in IDLE with random Q_VALID gaps
    sb_en = 1'b1;
    for (int i = 0; i < 96; i++) begin
      while ($urandom_range(0, 2) == 0) cyc(4'($urandom_range(0, 15)), 1'b0);
      gb_send(4'($urandom_range(0, 15)));
    end
    check("idle_aligned", ALIGNED, 0);
    check("idle_slip_count", SLIP_COUNT, 0);

    // nibbles 1..4 with Q_VALID high one clock in three
    wv = 0;
    for (int n = 1; n <= 4; n++) begin
      cyc(4'($urandom_range(0, 15)), 1'b0);
      if (WORD_VALID) wv++;
      cyc(4'($urandom_range(0, 15)), 1'b0);
      if (WORD_VALID) wv++;
      gb_send(4'(n));
      if (WORD_VALID) wv++;
      if (n == 4) begin
        check("gap_latency_valid", WORD_VALID, 1);
        check("gap_word", WORD_OUT, 16'h1234);
      end
    end
    cyc(4'h0, 1'b0);
    if (WORD_VALID) wv++;
    cyc(4'h0, 1'b0);
    if (WORD_VALID) wv++;
    check("gap_word_count", wv, 1);
    sb_drain("sb_drain_idle");

    // aligned training stream, then lock-loss behaviour
    do_reset();
    run_aligned("t1");
    send_word(bad_word()); check("t4_bad1", ALIGNED, 1);
    send_word(bad_word()); check("t4_bad2", ALIGNED, 1);
    send_word(PAT);        check("t4_good", ALIGNED, 1);
    send_word(bad_word()); check("t4_bad3a", ALIGNED, 1);
    send_word(bad_word()); check("t4_bad3b", ALIGNED, 1);
    send_word(bad_word());
    check("t4_unlock_aligned", ALIGNED, 0);
    check("t4_unlock_slip_count", SLIP_COUNT, 0);
    send_word(bad_word());
    check("t4_rehunt_pulse", BITSLIP_ADJ, 1);
    check("t4_rehunt_slip_count", SLIP_COUNT, 1);
    cyc(4'h0, 1'b0);
    check("t4_rehunt_pulse_end", BITSLIP_ADJ, 0);
    sb_drain("sb_drain_lock");

    // pattern offset by 2 nibbles at bit phase 0
    do_reset();
    sd_init(8, 1'b0);
    TRAIN_EN = 1'b1;
    for (int i = 0; i < 1500 && !ALIGNED; i++) sd_step();
    check("t2_aligned", ALIGNED, 1);
    check("t2_pulses", pulses, 8);
    check("t2_slip_count", SLIP_COUNT, 8);
    check("t2_word_out", WORD_OUT, PAT);

    // never-matching data exhausts the attempts
    do_reset();
    sd_init(0, 1'b1);
    TRAIN_EN = 1'b1;
    for (int i = 0; i < 3000 && !ALIGN_ERROR; i++) sd_step();
    check("t3_align_error", ALIGN_ERROR, 1);
    check("t3_pulses", pulses, MAX_ATTEMPTS);
    check("t3_aligned", ALIGNED, 0);
    check("t3_slip_count", SLIP_COUNT, MAX_ATTEMPTS);
    for (int i = 0; i < 30; i++) sd_step();
    check("t3_no_more_pulses", pulses, MAX_ATTEMPTS);
    check("t3_error_held", ALIGN_ERROR, 1);
    TRAIN_EN = 1'b0;
    cyc(4'h0, 1'b0);
    check("t3_error_clear", ALIGN_ERROR, 0);
    check("t3_idle_slip_count", SLIP_COUNT, 0);

    // reset while in WAIT
    do_reset();
    sd_init(0, 1'b1);
    TRAIN_EN = 1'b1;
    for (int i = 0; i < 300 && pulses == 0; i++) sd_step();
    check("t6a_pulse_seen", pulses, 1);
    for (int i = 0; i < 3; i++) sd_step();
    RST_N = 1'b0;
    cyc(4'h0, 1'b0);
    check_zero("t6a_rst");
    exp_q.delete();
    nq.delete();
    RST_N = 1'b1;
    run_aligned("t6a");
    sb_drain("sb_drain_t6a");

    // reset on the BITSLIP cycle
    do_reset();
    sd_init(0, 1'b1);
    TRAIN_EN = 1'b1;
    for (int i = 0; i < 300 && !BITSLIP_ADJ; i++) sd_step();
    check("t6b_pulse_seen", BITSLIP_ADJ, 1);
    RST_N = 1'b0;
    cyc(4'h0, 1'b0);
    check_zero("t6b_rst");
    exp_q.delete();
    nq.delete();
    RST_N = 1'b1;
    run_aligned("t6b");
    sb_drain("sb_drain_t6b");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
